// File: rtl/fetch_buffer.sv
// Instruction FIFO between prefetch and decode, with taken-branch flush and a
// squash window that drops stale prefetch packets still in flight.
module fetch_buffer #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned XLEN          = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_inst,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_npc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_npc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       squashing
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned SQW  = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_entry;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            push;
  logic            pop;

  // Handshake decode; flush and the squash window override both sides
  assign in_ready  = (count != CNTW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush & ~squashing;
  assign pop       = out_valid & out_ready & ~flush;

  assign head_entry = mem[head];
  assign out_inst   = out_valid ? head_entry.inst : '0;
  assign out_pc     = out_valid ? head_entry.pc   : '0;
  assign out_npc    = out_valid ? head_entry.npc  : '0;

  // Pointer and occupancy state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; contents are only visible while counted
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= '{inst: in_inst, pc: in_pc, npc: in_npc};
  end

  generate
    if (SQUASH_CYCLES > 0) begin : g_squash
      typedef enum logic {S_IDLE, S_SQUASH} state_t;
      state_t         state;
      state_t         state_next;
      logic [SQW-1:0] sq_cnt;
      logic [SQW-1:0] sq_cnt_next;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state  <= S_IDLE;
          sq_cnt <= '0;
        end else begin
          state  <= state_next;
          sq_cnt <= sq_cnt_next;
        end
      end

      // A flush (re)loads the window; otherwise count down and leave at zero
      always_comb begin
        state_next  = state;
        sq_cnt_next = sq_cnt;
        if (flush) begin
          state_next  = S_SQUASH;
          sq_cnt_next = SQW'(SQUASH_CYCLES);
        end else if (state == S_SQUASH) begin
          sq_cnt_next = sq_cnt - SQW'(1);
          if (sq_cnt == SQW'(1)) state_next = S_IDLE;
        end
      end

      assign squashing = (state == S_SQUASH);
    end else begin : g_no_squash
      assign squashing = 1'b0;
    end
  endgenerate

  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count <= CNTW'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset)
    !(pop && (count == '0)));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: fill, drain, streaming across wrap,
// flush/squash windows and asynchronous reset.
module tb_fetch_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned XLEN  = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_npc;
  logic            in_ready;
  logic            out_valid;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_npc;
  logic            out_ready;
  logic [3:0]      count;
  logic            squashing;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(DEPTH), .SQUASH_CYCLES(2), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_npc(in_npc),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_npc(out_npc), .out_ready(out_ready),
    .count(count), .squashing(squashing)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_npc   = pc + XLEN'(4);
    in_inst  = 32'hA500_0000 ^ 32'(pc);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    tick(); tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_squashing", 64'(squashing), 64'd0);
    check("rst_out_pc_zero", 64'(out_pc), 64'd0);
    reset = 1'b1;
    tick();

    // Fill to DEPTH, then offer a ninth packet that must be refused
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, XLEN'(32'h100 + 4 * i));
      tick();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_out_pc", 64'(out_pc), 64'h100);
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, XLEN'(32'h120));
    tick();
    check("ninth_count", 64'(count), 64'd8);
    check("ninth_out_pc", 64'(out_pc), 64'h100);

    // Drain in order
    drive(1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_pc", 64'(out_pc), 64'(32'h100 + 4 * i));
      check("drain_npc", 64'(out_npc), 64'(32'h104 + 4 * i));
      check("drain_inst", 64'(out_inst), 64'(32'hA500_0000 ^ (32'h100 + 4 * i)));
      tick();
    end
    check("drained_valid", 64'(out_valid), 64'd0);
    check("drained_count", 64'(count), 64'd0);

    // Stream with count held at 3 across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, XLEN'(32'h300 + 4 * k));
      tick();
    end
    check("stream_pre_count", 64'(count), 64'd3);
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, XLEN'(32'h300 + 4 * (j + 3)));
      check("stream_pc", 64'(out_pc), 64'(32'h300 + 4 * j));
      tick();
      check("stream_count", 64'(count), 64'd3);
    end
    out_ready = 1'b0;
    for (int k = 23; k < 25; k++) begin
      drive(1'b1, XLEN'(32'h300 + 4 * k));
      tick();
    end
    check("preflush_count", 64'(count), 64'd5);
    check("preflush_pc", 64'(out_pc), 64'(32'h300 + 4 * 20));

    // Flush with a packet and a pop request in the same cycle
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, XLEN'(32'h200));
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_sq1", 64'(squashing), 64'd1);
    drive(1'b1, XLEN'(32'h204));
    tick();
    check("flush_sq2", 64'(squashing), 64'd1);
    check("flush_drop1", 64'(count), 64'd0);
    drive(1'b1, XLEN'(32'h208));
    tick();
    check("flush_sq_end", 64'(squashing), 64'd0);
    check("flush_drop2", 64'(count), 64'd0);
    drive(1'b1, XLEN'(32'h400));
    tick();
    drive(1'b0, '0);
    check("post_sq_count", 64'(count), 64'd1);
    check("post_sq_pc", 64'(out_pc), 64'h400);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_sq_drain", 64'(count), 64'd0);

    // Back-to-back flush at cycles N and N+1
    flush = 1'b1;
    drive(1'b1, XLEN'(32'h500));
    tick();
    check("b2b_sq_n1", 64'(squashing), 64'd1);
    tick();
    flush = 1'b0;
    check("b2b_sq_n2", 64'(squashing), 64'd1);
    check("b2b_cnt_n2", 64'(count), 64'd0);
    tick();
    check("b2b_sq_n3", 64'(squashing), 64'd1);
    check("b2b_cnt_n3", 64'(count), 64'd0);
    tick();
    check("b2b_sq_n4", 64'(squashing), 64'd0);
    check("b2b_cnt_n4", 64'(count), 64'd0);
    tick();
    check("b2b_resume_cnt", 64'(count), 64'd1);
    check("b2b_resume_pc", 64'(out_pc), 64'h500);

    // Asynchronous reset between edges with four entries held
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, XLEN'(32'h600 + 4 * k));
      tick();
    end
    drive(1'b0, '0);
    check("arst_pre_count", 64'(count), 64'd4);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b1;
    drive(1'b1, XLEN'(32'h700));
    tick();
    drive(1'b0, '0);
    check("arst_resume_cnt", 64'(count), 64'd1);
    check("arst_resume_pc", 64'(out_pc), 64'h700);
    check("arst_resume_rdy", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction FIFO between the prefetch queue and the decoder.
- Accepts one PREFETCH_PACKET-style entry per cycle and holds up to DEPTH entries.
- Presents the oldest entry to decode through a valid/ready handshake.
- On a taken branch it flushes all held entries and squashes the stale packets the prefetch queue still emits during its registered-branch latency.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- SQUASH_CYCLES, 2, cycles after a flush during which in_valid is ignored; 0 disables squashing.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- flush  input  1  taken-branch flush (same cycle as the prefetch take_branch).
- in_valid  input  1  prefetch packet valid.
- in_inst  input  32  instruction word.
- in_pc  input  XLEN  PC of the instruction.
- in_npc  input  XLEN  PC+4.
- in_ready  output  1  buffer can accept an entry this cycle.
- out_valid  output  1  head entry valid.
- out_inst  output  32  head instruction.
- out_pc  output  XLEN  head PC.
- out_npc  output  XLEN  head NPC.
- out_ready  input  1  decoder consumes head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.
- squashing  output  1  squash window active.

Behaviour:
- Storage: circular array of DEPTH entries {inst, pc, npc}.
- Pointers: head and tail, $clog2(DEPTH) bits each, wrap naturally from DEPTH-1 to 0.
- Occupancy: count register of $clog2(DEPTH)+1 bits.
- Reset (reset==0, asynchronous):
  - head=0, tail=0, count=0, squash counter=0.
  - out_valid=0, in_ready=1, squashing=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- in_ready = (count != DEPTH). It is a function of registered state only and never depends on out_ready in the same cycle.
- push = in_valid & in_ready & ~flush & ~squashing.
- pop = out_valid & out_ready & ~flush.
- out_valid = (count != 0). out_inst, out_pc and out_npc are driven from the head entry; they are zero when empty.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1. There is no same-cycle bypass.
- Push and pop in the same cycle: both happen, count is unchanged, both pointers advance. This is legal at any count below DEPTH. At count==DEPTH, in_ready=0, so only the pop occurs.
- Empty: pop cannot occur because out_valid=0. out_ready is ignored.
- Flush has priority over everything in its cycle:
  - Next cycle: head=tail=0, count=0, out_valid=0.
  - Any push and pop in the flush cycle are suppressed.
- Squash FSM states: IDLE, SQUASH.
  - IDLE -> SQUASH on flush when SQUASH_CYCLES>0. The counter loads SQUASH_CYCLES.
  - In SQUASH: squashing=1, in_valid is discarded, and the counter decrements each cycle.
  - SQUASH -> IDLE when the counter reaches 0 after decrementing.
  - Window: squashing is high for exactly SQUASH_CYCLES cycles, starting the cycle after flush.
  - A flush during SQUASH reloads the counter to SQUASH_CYCLES and stays in SQUASH.
  - With SQUASH_CYCLES=0, the block stays in IDLE and squashing is tied to 0.
- Pops are permitted during SQUASH. The FIFO is empty right after a flush, so none can occur until new pushes land.
- in_ready is not forced low during squashing. The upstream stage ignores ready anyway, and its packets are dropped silently.
- count must equal (tail-head) mod DEPTH, except when full, where count==DEPTH and tail==head.
- Assertions: count never exceeds DEPTH; pop never occurs when count==0.

Test Plan:
- Reset then fill: after reset, drive in_valid=1 with pc=0x100,0x104,...,0x11C and out_ready=0 for 8 cycles. Required: count reaches 8, in_ready=0, a 9th packet (0x120) is not stored, out_pc=0x100 throughout.
- Drain order: from full, set out_ready=1 and in_valid=0 for 8 cycles. Required: out_pc sequence 0x100..0x11C, npc=pc+4, out_valid drops after the 8th pop, count=0.
- Simultaneous push/pop: with count=3, push and pop for 20 cycles. Required: count stays 3, output order matches input order across pointer wrap, no loss or duplication.
- Flush with squash: count=5, assert flush for 1 cycle while in_valid=1 (pc=0x200). Required:
  - Next cycle count=0, out_valid=0, squashing=1 for 2 cycles.
  - Packets 0x200, 0x204 and 0x208 presented in those cycles are dropped.
  - The first packet after the window (0x400) appears at out_pc one cycle later.
- Back-to-back flush: flush at cycles N and N+1. Required: squashing held through cycle N+3 and drops at N+4. No entries are accepted in between.
- Asynchronous reset mid-stream: pull reset low between clock edges with count=4. Required: out_valid=0 and count=0 immediately, before the next edge. After release, normal pushes resume with in_ready=1.
